// File: rtl/tdm_demux.sv
// ==== tdm_demux: 4-slot TDM receiver, double-buffered A..D outputs -- rev 1.0 ====
`default_nettype none

module tdm_demux #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in_data,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic             frame_valid,
  output logic             frame_err
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [1:0]       sel_nxt;
  logic [WIDTH-1:0] shadow [4];
  logic             publish;
  logic             start;
  logic             accept;
  logic             early_sof;
  logic             last_slot;

  // In COLLECT sel is always 01..11, so any SOF seen there aborts a partial frame.
  always_comb begin
    start     = in_valid & in_sof;
    accept    = in_valid & ~in_sof & (state == COLLECT);
    early_sof = start & (state == COLLECT);
    last_slot = accept & (sel == 2'b11);
    state_nxt = state;
    sel_nxt   = sel;
    if (start) begin
      state_nxt = COLLECT;
      sel_nxt   = 2'b01;
    end else if (accept) begin
      if (last_slot) begin
        state_nxt = IDLE;
        sel_nxt   = 2'b00;
      end else begin
        sel_nxt   = sel + 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 2'b00;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
    end
  end

  generate
    for (genvar i = 0; i < 4; i++) begin : g_shadow
      logic wr_en;
      if (i == 0) begin : g_slot0
        assign wr_en = start;
      end else begin : g_slotn
        assign wr_en = accept & (sel == 2'(i));
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow[i] <= '0;
        end else if (wr_en) begin
          shadow[i] <= in_data;
        end
      end
    end
  endgenerate

  // Publishing one cycle after slot 3 lets a back-to-back SOF overwrite shadow[0] safely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      publish     <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      A           <= '0;
      B           <= '0;
      C           <= '0;
      D           <= '0;
    end else begin
      publish     <= last_slot;
      frame_valid <= publish;
      frame_err   <= early_sof;
      if (publish) begin
        A <= shadow[0];
        B <= shadow[1];
        C <= shadow[2];
        D <= shadow[3];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux.sv
// ==== tb_tdm_demux: self-checking bench for tdm_demux (WIDTH=4 and WIDTH=1) -- rev 1.0 ====
`default_nettype none

module tb_tdm_demux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [3:0] in_data = 4'h0;

  logic [1:0] sel4, sel1;
  logic [3:0] a4, b4, c4, d4;
  logic       a1, b1, c1, d1;
  logic       fv4, fe4, fv1, fe1;

  int checks = 0;
  int errors = 0;
  int fv_count = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  tdm_demux #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .sel(sel4), .A(a4), .B(b4), .C(c4), .D(d4), .frame_valid(fv4), .frame_err(fe4)
  );

  tdm_demux u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data[0]),
    .sel(sel1), .A(a1), .B(b1), .C(c1), .D(d1), .frame_valid(fv1), .frame_err(fe1)
  );

  // Reference model: a frame is a list of samples that starts at SOF and is
  // published one cycle after its fourth sample arrives.
  logic [3:0] m_frame [$];
  logic [3:0] m_pend [4];
  logic [3:0] m_out [4];
  bit         m_pub_due;
  bit         m_fv;
  bit         m_fe;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_frame.delete();
        m_pub_due = 0;
        m_fv = 0;
        m_fe = 0;
        for (int k = 0; k < 4; k++) begin
          m_out[k] = 4'h0;
          m_pend[k] = 4'h0;
        end
      end else begin
        m_fv = m_pub_due;
        if (m_pub_due) m_out = m_pend;
        m_pub_due = 0;
        m_fe = 0;
        if (in_valid) begin
          if (in_sof) begin
            if (m_frame.size() != 0) m_fe = 1;
            m_frame.delete();
            m_frame.push_back(in_data);
          end else if (m_frame.size() != 0) begin
            m_frame.push_back(in_data);
            if (m_frame.size() == 4) begin
              for (int k = 0; k < 4; k++) m_pend[k] = m_frame[k];
              m_frame.delete();
              m_pub_due = 1;
            end
          end
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (fv4) fv_count++;
      if (chk_en) begin
        cmp("sel4", {14'h0, sel4}, {14'h0, 2'(m_frame.size())});
        cmp("sel1", {14'h0, sel1}, {14'h0, 2'(m_frame.size())});
        cmp("abcd4", {a4, b4, c4, d4}, {m_out[0], m_out[1], m_out[2], m_out[3]});
        cmp("abcd1", {12'h0, a1, b1, c1, d1},
            {12'h0, m_out[0][0], m_out[1][0], m_out[2][0], m_out[3][0]});
        cmp("fv", {14'h0, fv4, fv1}, {14'h0, m_fv, m_fv});
        cmp("fe", {14'h0, fe4, fe1}, {14'h0, m_fe, m_fe});
      end
    end
  end

  task automatic drive(input bit sof, input logic [3:0] d);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
  endtask

  task automatic send(input bit sof, input logic [3:0] d);
    @(negedge clk);
    drive(sof, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2);
    cmp("lit_reset_sel", {14'h0, sel4}, 16'h0);
    cmp("lit_reset_abcd", {a4, b4, c4, d4}, 16'h0000);

    // Nominal frame, one-bit values
    send(1, 4'h1); send(0, 4'h0); send(0, 4'h1); send(0, 4'h1);
    idle(1);
    cmp("lit_nom_fv_early", {15'h0, fv4}, 16'h0);
    idle(1);
    cmp("lit_nom_fv", {14'h0, fv4, fv1}, 16'h3);
    cmp("lit_nom_abcd1", {12'h0, a1, b1, c1, d1}, 16'hB);
    cmp("lit_nom_sel", {14'h0, sel1}, 16'h0);
    idle(1);
    cmp("lit_nom_fv_once", {15'h0, fv1}, 16'h0);

    // Gapped slots
    send(1, 4'h3); idle(2);
    cmp("lit_gap_sel1", {14'h0, sel4}, 16'h1);
    send(0, 4'h5); idle(3);
    cmp("lit_gap_sel2", {14'h0, sel4}, 16'h2);
    send(0, 4'h9); idle(2);
    cmp("lit_gap_sel3", {14'h0, sel4}, 16'h3);
    send(0, 4'hC); idle(2);
    cmp("lit_gap_sel0", {14'h0, sel4}, 16'h0);
    cmp("lit_gap_abcd", {a4, b4, c4, d4}, 16'h359C);

    // Early SOF aborts the partial frame 1,2
    send(1, 4'h1); send(0, 4'h2); send(1, 4'h7);
    @(negedge clk);
    cmp("lit_err_fe", {14'h0, fe4, fe1}, 16'h3);
    cmp("lit_err_hold", {a4, b4, c4, d4}, 16'h359C);
    drive(0, 4'h8);
    send(0, 4'h9); send(0, 4'hA); idle(2);
    cmp("lit_err_abcd", {a4, b4, c4, d4}, 16'h789A);

    // Reset mid-frame after slots A,B
    send(1, 4'hA); send(0, 4'hB);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    cmp("lit_rst_abcd", {a4, b4, c4, d4}, 16'h0000);
    cmp("lit_rst_sel", {14'h0, sel4}, 16'h0);
    cmp("lit_rst_pulses", {14'h0, fv4, fe4}, 16'h0);
    rst_n = 1'b1;

    // Non-SOF data in IDLE is dropped
    send(0, 4'h5); send(0, 4'h6); send(0, 4'hC); idle(2);
    cmp("lit_idle_sel", {14'h0, sel4}, 16'h0);
    cmp("lit_idle_abcd", {a4, b4, c4, d4}, 16'h0000);

    // Back-to-back frames 1000 then 0001
    fv_count = 0;
    send(1, 4'h1); send(0, 4'h0); send(0, 4'h0); send(0, 4'h0);
    send(1, 4'h0);
    @(negedge clk);
    cmp("lit_b2b_first", {12'h0, a1, b1, c1, d1}, 16'h8);
    drive(0, 4'h0);
    send(0, 4'h0); send(0, 4'h1); idle(3);
    cmp("lit_b2b_second", {12'h0, a1, b1, c1, d1}, 16'h1);
    cmp("lit_b2b_count", 16'(fv_count), 16'h2);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
